// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
// Word width, memory cell size and the word-to-byte shift all live here.
package if_prefetch_stage_pkg;

    localparam int WORD_LEN_DEF  = 32;
    localparam int MEM_CELL_SIZE = 8;
    localparam int BR_SHIFT      = 2;
    localparam int INSTR_BYTES   = WORD_LEN_DEF / MEM_CELL_SIZE;

    // IDLE: free to issue. WAIT: one live request. DROP: one stale request to swallow.
    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP
    } fetch_state_e;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Bundle of branch, stall, instruction-memory and decode-side signals around the fetch stage.
// The master modport is the fetch stage itself; the slave modport is its surroundings.
interface if_prefetch_stage_if #(
    parameter int WORD_LEN = if_prefetch_stage_pkg::WORD_LEN_DEF
);

    logic                brTaken;
    logic [WORD_LEN-1:0] brBasePC;
    logic [WORD_LEN-1:0] brOffset;
    logic                freeze;

    logic                imem_req;
    logic [WORD_LEN-1:0] imem_addr;
    logic                imem_valid;
    logic [WORD_LEN-1:0] imem_rdata;

    logic [WORD_LEN-1:0] PC;
    logic [WORD_LEN-1:0] instruction;
    logic                instr_valid;

    modport master (
        input  brTaken,
        input  brBasePC,
        input  brOffset,
        input  freeze,
        input  imem_valid,
        input  imem_rdata,
        output imem_req,
        output imem_addr,
        output PC,
        output instruction,
        output instr_valid
    );

    modport slave (
        output brTaken,
        output brBasePC,
        output brOffset,
        output freeze,
        output imem_valid,
        output imem_rdata,
        input  imem_req,
        input  imem_addr,
        input  PC,
        input  instruction,
        input  instr_valid
    );

endinterface

// File: rtl/if_prefetch_stage_fetch_fifo.sv
// Power-of-two circular queue holding {address, instruction} entries for the fetch stage.
// The caller must not push into a full queue unless it pops in the same cycle.
module fetch_fifo import if_prefetch_stage_pkg::*; #(
    parameter int WIDTH = 2 * WORD_LEN_DEF,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH + 1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    assign w_doPop  = pop && !empty && !flush;
    assign w_doPush = push && !flush;

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rdPtr];
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch stage: issues one memory request at a time into a small queue,
// redirects on taken branches and discards any response that was in flight at the time.
module if_prefetch_stage import if_prefetch_stage_pkg::*; #(
    parameter int                  WORD_LEN = WORD_LEN_DEF,
    parameter int                  DEPTH    = 4,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    if_prefetch_stage_if.master bus
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 2 * WORD_LEN;

    fetch_state_e        r_state;
    fetch_state_e        w_stateNext;
    logic [WORD_LEN-1:0] r_fetchPc;
    logic [WORD_LEN-1:0] r_reqAddr;
    logic [WORD_LEN-1:0] r_pcHold;

    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_room;
    logic [CNT_W-1:0]    w_count;
    logic [ENTRY_W-1:0]  w_head;
    logic [WORD_LEN-1:0] w_headAddr;
    logic [WORD_LEN-1:0] w_headInstr;
    logic [WORD_LEN-1:0] w_headPc;
    logic [WORD_LEN-1:0] w_nextPc;
    logic [WORD_LEN-1:0] w_brTarget;

    assign w_brTarget  = bus.brBasePC + (bus.brOffset << BR_SHIFT);
    assign w_nextPc    = r_fetchPc + WORD_LEN'(INSTR_BYTES);
    assign w_room      = (int'(w_count) + 1) <= DEPTH;
    assign w_pop       = !w_empty && !bus.freeze && !bus.brTaken;
    assign w_headAddr  = w_head[ENTRY_W-1 -: WORD_LEN];
    assign w_headInstr = w_head[WORD_LEN-1:0];
    assign w_headPc    = w_headAddr + WORD_LEN'(INSTR_BYTES);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fetchFifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (bus.brTaken),
        .i_wdata ({r_reqAddr, bus.imem_rdata}),
        .o_rdata (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // A branch in WAIT turns the live request stale unless its answer lands this very cycle.
    always_comb begin
        w_stateNext = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            FS_IDLE: begin
                if (!bus.brTaken && w_room) begin
                    w_req       = 1'b1;
                    w_stateNext = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (bus.imem_valid) begin
                    w_push      = !bus.brTaken && (!w_full || w_pop);
                    w_stateNext = FS_IDLE;
                end else if (bus.brTaken) begin
                    w_stateNext = FS_DROP;
                end
            end
            FS_DROP: begin
                if (bus.imem_valid) begin
                    w_stateNext = FS_IDLE;
                end
            end
            default: begin
                w_stateNext = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FS_IDLE;
            r_fetchPc <= RESET_PC;
            r_reqAddr <= RESET_PC;
            r_pcHold  <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            if (bus.brTaken) begin
                r_fetchPc <= w_brTarget;
            end else if (w_req) begin
                r_fetchPc <= w_nextPc;
                r_reqAddr <= r_fetchPc;
            end
            if (!w_empty) begin
                r_pcHold <= w_headPc;
            end
        end
    end

    // Gating with rst keeps the request low while reset is held.
    assign bus.imem_req    = w_req && !rst;
    assign bus.imem_addr   = r_fetchPc;
    assign bus.instr_valid = !w_empty;
    assign bus.instruction = w_empty ? '0 : w_headInstr;
    assign bus.PC          = w_empty ? r_pcHold : w_headPc;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: streaming, freeze, branches, stale drops, wrap and reset.
module tb_if_prefetch_stage;
    import if_prefetch_stage_pkg::*;

    localparam int WL    = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    int          testCount = 0;
    int          failCount = 0;
    int          memLat = 1;
    logic        memPend;
    logic [31:0] memAddr;
    int          memCnt;
    int          reqTotal = 0;
    int          reqBase = 0;
    logic [31:0] lastReqAddr = '0;
    logic        injValid = 1'b0;

    if_prefetch_stage_if #(.WORD_LEN(WL)) bus ();

    if_prefetch_stage #(
        .WORD_LEN (WL),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // Memory model: requests seen on the falling edge, answered memLat cycles later.
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        memPend = 1'b0;
        memAddr = '0;
        memCnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_valid = 1'b0;
            bus.imem_rdata = '0;
            if (rst) begin
                memPend = 1'b0;
            end else if (memPend) begin
                memCnt--;
                if (memCnt <= 0) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = instrOf(memAddr);
                    memPend = 1'b0;
                end
            end
            if (injValid) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                memPend     = 1'b1;
                memAddr     = bus.imem_addr;
                memCnt      = memLat;
                reqTotal++;
                lastReqAddr = bus.imem_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic br, input logic [31:0] base,
                                 input logic [31:0] off, input logic frz);
        bus.brTaken  = br;
        bus.brBasePC = base;
        bus.brOffset = off;
        bus.freeze   = frz;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_req",   32'(bus.imem_req), 32'd0);
        checkOutput("rst_addr",  bus.imem_addr, 32'h0);
        checkOutput("rst_pc",    bus.PC, 32'h0);
        checkOutput("rst_instr", bus.instruction, 32'h0);
        checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);

        // Streaming with a 1-cycle memory and no stall
        rst = 1'b0;
        #1;
        checkOutput("c0_req",  32'(bus.imem_req), 32'd1);
        checkOutput("c0_addr", bus.imem_addr, 32'h0);
        tick();
        checkOutput("c1_req",  32'(bus.imem_req), 32'd0);
        tick();
        checkOutput("c2_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("c2_pc",    bus.PC, 32'h4);
        checkOutput("c2_instr", bus.instruction, 32'h5A00_0000);
        checkOutput("c2_addr",  bus.imem_addr, 32'h4);
        tick();
        checkOutput("c3_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("c3_instr", bus.instruction, 32'h0);
        checkOutput("c3_pc",    bus.PC, 32'h4);
        tick();
        checkOutput("c4_pc",    bus.PC, 32'h8);
        checkOutput("c4_instr", bus.instruction, 32'h5A00_0004);
        checkOutput("c4_addr",  bus.imem_addr, 32'h8);
        tick();
        tick();
        checkOutput("c6_pc",    bus.PC, 32'hC);
        checkOutput("c6_instr", bus.instruction, 32'h5A00_0008);

        // Freeze with three entries queued, then reset mid-stream
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (4) tick();
        checkOutput("c10_pc",    bus.PC, 32'hC);
        checkOutput("c10_instr", bus.instruction, 32'h5A00_0008);
        checkOutput("c10_req",   32'(bus.imem_req), 32'd1);
        checkOutput("c10_addr",  bus.imem_addr, 32'h14);
        rst = 1'b1;
        #1;
        checkOutput("mrst_req",   32'(bus.imem_req), 32'd0);
        checkOutput("mrst_addr",  bus.imem_addr, 32'h0);
        checkOutput("mrst_pc",    bus.PC, 32'h0);
        checkOutput("mrst_instr", bus.instruction, 32'h0);
        checkOutput("mrst_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        injValid = 1'b1;
        tick();
        injValid = 1'b0;
        rst      = 1'b0;
        reqBase  = reqTotal;
        #1;
        checkOutput("d0_req",  32'(bus.imem_req), 32'd1);
        checkOutput("d0_addr", bus.imem_addr, 32'h0);
        tick();
        tick();
        checkOutput("d2_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("d2_pc",    bus.PC, 32'h4);
        checkOutput("d2_instr", bus.instruction, 32'h5A00_0000);
        repeat (8) tick();
        checkOutput("d10_req",     32'(bus.imem_req), 32'd0);
        checkOutput("d10_nreq",    32'(reqTotal - reqBase), 32'd4);
        checkOutput("d10_lastreq", lastReqAddr, 32'hC);
        checkOutput("d10_pc",      bus.PC, 32'h4);
        checkOutput("d10_instr",   bus.instruction, 32'h5A00_0000);

        // Pop two, then branch with a response landing in the same cycle
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("d12_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("d12_pc",    bus.PC, 32'hC);
        applyStimulus(1'b1, 32'h100, 32'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h100, 32'd3, 1'b1);
        checkOutput("d13_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("d13_instr", bus.instruction, 32'h0);
        checkOutput("d13_pc",    bus.PC, 32'hC);
        #1;
        checkOutput("d13_req",  32'(bus.imem_req), 32'd1);
        checkOutput("d13_addr", bus.imem_addr, 32'h10C);
        tick();
        tick();
        checkOutput("d15_pc",    bus.PC, 32'h110);
        checkOutput("d15_instr", bus.instruction, 32'h5A00_010C);
        checkOutput("d15_addr",  bus.imem_addr, 32'h110);

        // Branch with a 5-cycle request outstanding, then a second branch while dropping
        memLat = 5;
        tick();
        applyStimulus(1'b1, 32'h200, 32'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h200, 32'd0, 1'b1);
        checkOutput("d17_valid", 32'(bus.instr_valid), 32'd0);
        #1;
        checkOutput("d17_req", 32'(bus.imem_req), 32'd0);
        tick();
        applyStimulus(1'b1, 32'h300, 32'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h300, 32'd1, 1'b1);
        #1;
        checkOutput("d19_req", 32'(bus.imem_req), 32'd0);
        tick();
        checkOutput("d20_req",   32'(bus.imem_req), 32'd0);
        checkOutput("d20_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        memLat = 1;
        checkOutput("d21_req",   32'(bus.imem_req), 32'd1);
        checkOutput("d21_addr",  bus.imem_addr, 32'h304);
        checkOutput("d21_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("d21_instr", bus.instruction, 32'h0);
        tick();
        tick();
        checkOutput("d23_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("d23_pc",    bus.PC, 32'h308);
        checkOutput("d23_instr", bus.instruction, 32'h5A00_0304);

        // Target near the top of the address space; offset top bits are shifted out
        applyStimulus(1'b1, 32'hFFFF_FFF0, 32'h4000_0003, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        checkOutput("d24_valid", 32'(bus.instr_valid), 32'd0);
        #1;
        checkOutput("d24_req",  32'(bus.imem_req), 32'd1);
        checkOutput("d24_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        checkOutput("d26_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("d26_pc",    bus.PC, 32'h0);
        checkOutput("d26_instr", bus.instruction, 32'hA5FF_FFFC);
        checkOutput("d26_req",   32'(bus.imem_req), 32'd1);
        checkOutput("d26_addr",  bus.imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameter WORD_LEN, default 32: PC, instruction and memory data width.
REQ-002 Parameter DEPTH, default 4: prefetch queue entries, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 brTaken  in  1  redirect fetch this cycle.
REQ-007 brBasePC  in  WORD_LEN  base address for the redirect, supplied by ID.
REQ-008 brOffset  in  WORD_LEN  word offset; target = brBasePC + (brOffset << 2).
REQ-009 freeze  in  1  downstream stall; head entry is held.
REQ-010 imem_req  out  1  single-cycle fetch request pulse.
REQ-011 imem_addr  out  WORD_LEN  fetch address, valid while imem_req is high.
REQ-012 imem_valid  in  1  response strobe, at least 1 cycle after the request.
REQ-013 imem_rdata  in  WORD_LEN  response instruction word.
REQ-014 PC  out  WORD_LEN  address of the head instruction plus 4.
REQ-015 instruction  out  WORD_LEN  head instruction word.
REQ-016 instr_valid  out  1  head entry present.

Function
REQ-017 Internal state: fetch PC, FIFO of {addr, instr} with count 0..DEPTH, outstanding flag, drop flag.
REQ-018 Only one request is outstanding at a time.
REQ-019 imem_req is asserted only when all of the following hold: no request is outstanding, drop is clear, count + 1 <= DEPTH, and brTaken is low.
REQ-020 On imem_req, imem_addr equals the fetch PC; the fetch PC then advances by 4, wrapping modulo 2^WORD_LEN.
REQ-021 On imem_valid with drop clear, {address, imem_rdata} is pushed and outstanding clears.
REQ-022 A pushed entry is visible on the outputs no earlier than the cycle after imem_valid, so minimum request-to-instr_valid latency is 2 cycles.
REQ-023 Pop occurs when instr_valid is high and freeze is low; simultaneous push and pop leaves count unchanged.
REQ-024 While freeze is high, PC, instruction and instr_valid hold, and fetching continues until the queue is full.
REQ-025 When full, no request is issued until a pop occurs.
REQ-026 brTaken has priority over push, pop and freeze. On the next edge the queue empties, the fetch PC loads the target, and instr_valid is low.
REQ-027 On brTaken with a request outstanding, or with imem_valid in the same cycle as brTaken, that response is discarded. drop is set until the stale response arrives, and no new request is issued before then.
REQ-028 A brTaken arriving while drop is set reloads the fetch PC only; drop remains set.
REQ-029 When instr_valid is low, instruction reads 0 and PC holds its last value.
REQ-030 Target arithmetic is modulo 2^WORD_LEN; the shift discards the top 2 bits of brOffset.

Reset
REQ-031 rst asynchronously forces: fetch PC = RESET_PC, count = 0, outstanding = 0, drop = 0.
REQ-032 During reset the outputs are: imem_req = 0, imem_addr = RESET_PC, PC = RESET_PC, instruction = 0, instr_valid = 0.
REQ-033 A response arriving in the cycle rst deasserts is ignored.
REQ-034 The first request is issued on the first clock edge after rst deasserts.

Structure
REQ-035 WORD_LEN default, MEM_CELL_SIZE and the shift constant 2 live in the shared defines file; RESET_PC stays a module parameter.
REQ-036 Queue storage and pointers are in one sub-module, fetch_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, full, empty, count).
REQ-037 Branch-target adder and request control stay in the top module; there is no combinational path from imem_valid to imem_req.

Verification
REQ-038 Reset, 1-cycle memory, freeze = 0: requests go to addresses 0x0, 0x4, 0x8 on alternating cycles, and the outputs show PC = 0x4, 0x8, 0xC with the matching words.
REQ-039 freeze held 10 cycles with DEPTH = 4: exactly 4 entries are fetched, imem_req stays low afterwards, and the outputs hold head PC = 0x4.
REQ-040 brTaken with brBasePC = 0x100 and brOffset = 3 while 2 entries are queued: the next cycle has instr_valid = 0, the next request goes to 0x10C, and the output shows PC = 0x110.
REQ-041 brTaken while a response is outstanding with 5-cycle latency: the stale word is never output, and the first request after the branch follows that stale imem_valid.
REQ-042 Fetch PC = 0xFFFFFFFC: the next request wraps to 0x0 and the head shows PC = 0x0.
REQ-043 rst asserted mid-stream with 3 entries queued: all outputs immediately return to their reset values, and fetch restarts at RESET_PC.
